// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: streams words from a 1-cycle-latency program memory
// into a small FIFO and hands them to the processor over a valid/ready handshake.
module instr_fetch_queue #(
    parameter int          ADDR_W      = 8,
    parameter int          DEPTH       = 4,
    parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [23:0]              mem_rdata,
    output logic [7:0]               opcode,
    output logic [7:0]               operand1,
    output logic [7:0]               operand2,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              inflight_q;
    logic              inflight_top_q;
    logic              top_issued_q;
    logic              done_q;
    logic [PW:0]       wr_ptr_q;
    logic [PW:0]       rd_ptr_q;
    logic [23:0]       fifo_mem [DEPTH];

    logic [PW:0]       count;
    logic [PW+1:0]     demand;
    logic [PW+1:0]     budget;
    logic              pop;
    logic              capture;
    logic              halt_now;
    logic              push;
    logic              can_issue;
    logic [23:0]       head;

    always_comb begin
        count       = wr_ptr_q - rd_ptr_q;
        instr_valid = (count != '0);
        pop         = instr_valid & instr_ready;
        capture     = (state_q == S_FETCH) & inflight_q;
        halt_now    = capture & (mem_rdata[23:16] == HALT_OPCODE);
        push        = capture & ~halt_now;
        // Credit check: everything already queued or in flight, minus the slot freed this cycle.
        demand      = {1'b0, count} + {{(PW+1){1'b0}}, inflight_q};
        budget      = (PW+2)'(DEPTH) + {{(PW+1){1'b0}}, pop};
        can_issue   = (demand < budget);
        mem_rd      = (state_q == S_FETCH) & ~top_issued_q & ~halt_now & can_issue;
        mem_addr    = mem_rd ? pc_q : '0;
        head        = fifo_mem[rd_ptr_q[PW-1:0]];
        opcode      = instr_valid ? head[23:16] : 8'h00;
        operand1    = instr_valid ? head[15:8]  : 8'h00;
        operand2    = instr_valid ? head[7:0]   : 8'h00;
        fill_level  = count;
        done        = done_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pc_q           <= '0;
            inflight_q     <= 1'b0;
            inflight_top_q <= 1'b0;
            top_issued_q   <= 1'b0;
            done_q         <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
        end else begin
            inflight_q     <= mem_rd;
            inflight_top_q <= mem_rd & (pc_q == TOP_ADDR);
            // pc parks on the top address instead of wrapping back to 0.
            if (mem_rd) begin
                if (pc_q == TOP_ADDR) begin
                    top_issued_q <= 1'b1;
                end else begin
                    pc_q <= pc_q + ADDR_W'(1);
                end
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_FETCH;
                        pc_q         <= '0;
                        top_issued_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (halt_now || (capture && inflight_top_q)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (count == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q      <= S_FETCH;
                        pc_q         <= '0;
                        top_issued_q <= 1'b0;
                        done_q       <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized scoreboard bench for instr_fetch_queue with a program-memory responder
// and a reference model that derives the expected instruction stream from the program image.
module tb_instr_fetch_queue;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;
    localparam int NWORDS = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic              start;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_rdata;
    logic [7:0]        opcode;
    logic [7:0]        operand1;
    logic [7:0]        operand2;
    logic              instr_valid;
    logic              instr_ready;
    logic              done;
    logic [2:0]        fill_level;

    instr_fetch_queue #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .HALT_OPCODE(8'hFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .opcode     (opcode),
        .operand1   (operand1),
        .operand2   (operand2),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .done       (done),
        .fill_level (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] prog [NWORDS];
    logic [23:0] exp_q [$];
    int          n_cmp;
    int          n_fail;
    int          next_addr;
    int          exp_reads;
    int          xfers;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: the stream is every word from address 0 up to (not including)
    // the first HALT, or the whole memory if there is none.
    function automatic void build_expected();
        exp_q.delete();
        exp_reads = NWORDS;
        for (int i = 0; i < NWORDS; i++) begin
            if (prog[i][23:16] == 8'hFF) begin
                exp_reads = i + 1;
                break;
            end
            exp_q.push_back(prog[i]);
        end
        next_addr = 0;
        xfers     = 0;
    endfunction

    function automatic logic [23:0] rand_word();
        return {8'($urandom_range(0, 254)), 16'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input bit accepted);
        if (accepted) build_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (accepted) check("done_cleared_on_start", done, 0);
    endtask

    // mode 0: hold ready, 1: random ready, 2: toggle ready every cycle
    task automatic run_to_done(input int mode, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (mode == 1) instr_ready = 1'($urandom);
            else if (mode == 2) instr_ready = ~instr_ready;
            tick();
            if (done) break;
        end
        check("done_reached", done, 1);
        check("all_delivered_left", exp_q.size(), 0);
        check("read_count", next_addr, exp_reads);
        check("empty_at_done", instr_valid, 0);
        $display("run finished: %0d transfers, %0d reads, done=%0b", xfers, next_addr, done);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; next_addr = 0; exp_reads = 0; xfers = 0;
        reset = 1'b1; start = 1'b0; instr_ready = 1'b0; mem_rdata = '0;
        for (int i = 0; i < NWORDS; i++) prog[i] = 24'h0;

        // Program memory responder: data valid the cycle after each read strobe, junk otherwise.
        fork
            begin : mem_model
                logic              rd;
                logic [ADDR_W-1:0] a;
                forever begin
                    @(negedge clk);
                    rd = mem_rd;
                    a  = mem_addr;
                    @(posedge clk);
                    #1;
                    mem_rdata = rd ? prog[a] : 24'($urandom);
                end
            end
            begin : monitor
                logic        hold_prev;
                logic [23:0] prev_head;
                logic [23:0] head;
                hold_prev = 1'b0;
                prev_head = '0;
                forever begin
                    @(negedge clk);
                    if (reset) begin
                        hold_prev = 1'b0;
                    end else begin
                        head = {opcode, operand1, operand2};
                        if (mem_rd) begin
                            check("rd_within_program", (next_addr < NWORDS) ? 1 : 0, 1);
                            check("rd_addr_sequence", mem_addr, next_addr);
                            next_addr++;
                        end
                        if (fill_level == 3'(DEPTH) && !instr_ready) check("no_read_when_full", mem_rd, 0);
                        check("fill_bounded", (fill_level <= 3'(DEPTH)) ? 1 : 0, 1);
                        check("valid_matches_fill", instr_valid, (fill_level != 0) ? 1 : 0);
                        if (!instr_valid) check("head_zero_when_invalid", head, 0);
                        if (hold_prev) begin
                            check("stall_valid_held", instr_valid, 1);
                            check("stall_head_stable", head, prev_head);
                        end
                        if (instr_valid && instr_ready) begin
                            xfers++;
                            if (exp_q.size() == 0) begin
                                n_cmp++;
                                n_fail++;
                                $display("FAIL unexpected_transfer: actual %06h required none at %0t", head, $time);
                            end else begin
                                check("transfer_data", head, exp_q.pop_front());
                            end
                        end
                        hold_prev = instr_valid && !instr_ready;
                        prev_head = head;
                    end
                end
            end
        join_none

        tick(); tick();
        check("rst_fill", fill_level, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_done", done, 0);
        check("rst_head", {opcode, operand1, operand2}, 0);
        reset = 1'b0;
        tick();

        // Two instructions then HALT, consumer always ready.
        prog[0] = 24'h010203; prog[1] = 24'h040506; prog[2] = 24'hFF0000;
        for (int i = 3; i < NWORDS; i++) prog[i] = rand_word();
        instr_ready = 1'b1;
        start_run(1);
        run_to_done(0, 40);

        // Ten words then HALT with a long consumer stall: queue must saturate without loss.
        for (int i = 0; i < 10; i++) prog[i] = rand_word();
        prog[10] = 24'hFF1234;
        instr_ready = 1'b0;
        start_run(1);
        for (int i = 0; i < 20; i++) tick();
        check("fill_saturated", fill_level, DEPTH);
        check("no_read_while_stalled", mem_rd, 0);
        instr_ready = 1'b1;
        run_to_done(0, 60);

        // No HALT anywhere: fetch must stop at the top address without wrapping.
        for (int i = 0; i < NWORDS; i++) prog[i] = 24'h000001;
        start_run(1);
        run_to_done(1, 200);

        // HALT at address 0: nothing delivered, done quickly.
        prog[0] = 24'hFF0000;
        instr_ready = 1'b1;
        start_run(1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("halt0_never_valid", instr_valid, 0);
        end
        check("halt0_done_within_4", done, 1);
        check("halt0_reads", next_addr, 1);

        // Reset in the middle of a fetch with three entries queued.
        for (int i = 0; i < 10; i++) prog[i] = rand_word();
        prog[10] = 24'hFF0000;
        instr_ready = 1'b0;
        start_run(1);
        for (int i = 0; i < 20; i++) begin
            if (fill_level == 3) break;
            tick();
        end
        check("reached_fill3", fill_level, 3);
        reset = 1'b1;
        tick();
        check("midrst_fill", fill_level, 0);
        check("midrst_valid", instr_valid, 0);
        check("midrst_mem_rd", mem_rd, 0);
        check("midrst_done", done, 0);
        check("midrst_head", {opcode, operand1, operand2}, 0);
        reset = 1'b0;
        exp_q.delete();
        tick();
        start_run(1);
        run_to_done(1, 100);

        // Twelve words, ready toggling, and a start pulse during FETCH that must be ignored.
        for (int i = 0; i < 12; i++) prog[i] = rand_word();
        prog[12] = 24'hFFABCD;
        instr_ready = 1'b1;
        start_run(1);
        for (int i = 0; i < 5; i++) begin
            instr_ready = ~instr_ready;
            tick();
        end
        start_run(0);
        run_to_done(2, 100);

        // Random programs with a random HALT position (NWORDS means no HALT) and random ready.
        for (int t = 0; t < 4; t++) begin
            int hp;
            hp = $urandom_range(0, NWORDS);
            for (int i = 0; i < NWORDS; i++) prog[i] = (i == hp) ? {8'hFF, 16'($urandom)} : rand_word();
            start_run(1);
            run_to_done(1, 200);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
